// File: rtl/pwm_pkg.sv
// Shared PWM encode/decode constants, FSM state type and helpers.
package pwm_pkg;

    localparam int unsigned VALUE_W            = 16;
    localparam logic [15:0] GUARD_ERROR        = 16'h8000;
    localparam int unsigned GUARD_TIME_ON_MIN  = 800;
    localparam int unsigned GUARD_TIME_ON_MAX  = 2600;
    localparam int unsigned GUARD_TIME_OFF_MAX = 20000;
    localparam int unsigned US_PER_S           = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

    // Prescale terminal count for a one-microsecond tick.
    function automatic int unsigned clk_divider(input int unsigned clock_freq);
        return (clock_freq / US_PER_S) - 1;
    endfunction

    function automatic logic [15:0] clamp_width(input logic [15:0] width,
                                                 input logic [15:0] lo,
                                                 input logic [15:0] hi);
        if (width < lo) return lo;
        if (width > hi) return hi;
        return width;
    endfunction

endpackage

// File: rtl/pwm_us_tick.sv
// Microsecond prescaler: one-cycle tick every clk_divider(clockFreq)+1 clocks.
module pwm_us_tick
    import pwm_pkg::*;
#(
    parameter int unsigned clockFreq = 50000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick_c
);

    localparam int unsigned DIV   = clk_divider(clockFreq);
    localparam int unsigned CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

    logic [CNT_W-1:0] count;

    assign o_tick_c = (count == CNT_W'(DIV));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear || o_tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_encode.sv
// Servo-style PWM generator: latched microsecond width, fixed frame period,
// new widths taken from a one-deep pending slot at frame boundaries only.
module pwm_encode
    import pwm_pkg::*;
#(
    parameter int unsigned clockFreq = 50000000,
    parameter int unsigned FRAME_US  = GUARD_TIME_OFF_MAX,
    parameter int unsigned MIN_US    = GUARD_TIME_ON_MIN,
    parameter int unsigned MAX_US    = GUARD_TIME_ON_MAX
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_value_valid,
    input  logic [15:0] i_value,
    output logic        o_value_ready,
    output logic        o_pwm,
    output logic        o_frame_start,
    output logic        o_clamped,
    output logic        o_error
);

    localparam logic [15:0] FRAME_LAST = 16'(FRAME_US - 1);
    localparam logic [15:0] MIN_W      = 16'(MIN_US);
    localparam logic [15:0] MAX_W      = 16'(MAX_US);

    if (MAX_US >= FRAME_US) begin : g_bad_frame
        $error("pwm_encode: MAX_US must be smaller than FRAME_US");
    end
    if (MIN_US > MAX_US || MIN_US == 0) begin : g_bad_limits
        $error("pwm_encode: MIN_US must be nonzero and not above MAX_US");
    end

    pwm_state_e  state;
    logic [15:0] us_count;
    logic [15:0] active;
    logic [15:0] pending;
    logic        pending_full;

    logic        tick_c;
    logic        clear_c;
    logic        accept_c;
    logic        guard_c;
    logic [15:0] raw_c;
    logic [15:0] width_c;

    assign accept_c = i_value_valid && o_value_ready;
    assign guard_c  = (i_value & GUARD_ERROR) != 16'd0;
    assign raw_c    = {1'b0, i_value[14:0]};
    assign width_c  = clamp_width(raw_c, MIN_W, MAX_W);
    // Idle load restarts the prescaler so the first high time is exact.
    assign clear_c  = (state == ST_IDLE) && pending_full;

    pwm_us_tick #(
        .clockFreq (clockFreq)
    ) u_us_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (clear_c),
        .o_tick_c (tick_c)
    );

    // Accept only fills an empty slot and load only drains a full one,
    // so the two never contend for pending in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            us_count      <= '0;
            active        <= '0;
            pending       <= '0;
            pending_full  <= 1'b0;
            o_value_ready <= 1'b1;
            o_pwm         <= 1'b0;
            o_frame_start <= 1'b0;
            o_clamped     <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            o_clamped     <= 1'b0;
            o_error       <= 1'b0;

            if (accept_c) begin
                if (guard_c) begin
                    o_error <= 1'b1;
                end else begin
                    pending       <= width_c;
                    pending_full  <= 1'b1;
                    o_value_ready <= 1'b0;
                    o_clamped     <= (width_c != raw_c);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pending_full) begin
                        active        <= pending;
                        pending_full  <= 1'b0;
                        o_value_ready <= 1'b1;
                        us_count      <= '0;
                        o_frame_start <= 1'b1;
                        o_pwm         <= 1'b1;
                        state         <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick_c) begin
                        us_count <= us_count + 16'd1;
                        if (us_count + 16'd1 == active) begin
                            o_pwm <= 1'b0;
                            state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (tick_c) begin
                        if (us_count == FRAME_LAST) begin
                            us_count      <= '0;
                            o_frame_start <= 1'b1;
                            o_pwm         <= 1'b1;
                            state         <= ST_HIGH;
                            if (pending_full) begin
                                active        <= pending;
                                pending_full  <= 1'b0;
                                o_value_ready <= 1'b1;
                            end
                        end else begin
                            us_count <= us_count + 16'd1;
                        end
                    end
                end
                default: begin
                    o_pwm <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_encode.sv
// Directed bench for pwm_encode with a scaled clock: 4 clocks per us, 200 us frame.
`timescale 1ns/1ps
module tb_pwm_encode;

    localparam int unsigned CLK_HZ   = 4000000;
    localparam int unsigned FRAME    = 200;
    localparam int unsigned MINW     = 20;
    localparam int unsigned MAXW     = 60;
    localparam int unsigned CPU      = 4;
    localparam int unsigned FRAME_CK = FRAME * CPU;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_value_valid = 1'b0;
    logic [15:0] i_value = 16'd0;
    logic        o_value_ready;
    logic        o_pwm;
    logic        o_frame_start;
    logic        o_clamped;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int unsigned rise_cnt = 0, fall_cnt = 0, fs_cnt = 0, cl_cnt = 0, er_cnt = 0;
    int unsigned rise_cyc = 0, fall_cyc = 0;
    int unsigned high_len = 0, low_len = 0, period = 0;
    logic        prev_pwm = 1'b0;

    pwm_encode #(
        .clockFreq (CLK_HZ),
        .FRAME_US  (FRAME),
        .MIN_US    (MINW),
        .MAX_US    (MAXW)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_value_valid (i_value_valid),
        .i_value       (i_value),
        .o_value_ready (o_value_ready),
        .o_pwm         (o_pwm),
        .o_frame_start (o_frame_start),
        .o_clamped     (o_clamped),
        .o_error       (o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Edge timestamps and pulse counts, sampled on the falling clock edge.
    always @(negedge i_clk) begin
        if (o_pwm === 1'b1 && prev_pwm === 1'b0) begin
            rise_cnt = rise_cnt + 1;
            period   = cyc - rise_cyc;
            low_len  = cyc - fall_cyc;
            rise_cyc = cyc;
        end
        if (o_pwm === 1'b0 && prev_pwm === 1'b1) begin
            fall_cnt = fall_cnt + 1;
            high_len = cyc - rise_cyc;
            fall_cyc = cyc;
        end
        if (o_frame_start === 1'b1) fs_cnt = fs_cnt + 1;
        if (o_clamped === 1'b1) cl_cnt = cl_cnt + 1;
        if (o_error === 1'b1) er_cnt = er_cnt + 1;
        prev_pwm = o_pwm;
    end

    task automatic write_word(input logic [15:0] v);
        @(posedge i_clk); #1;
        i_value_valid = 1'b1;
        i_value       = v;
        @(posedge i_clk); #1;
        i_value_valid = 1'b0;
        i_value       = 16'd0;
    endtask

    task automatic wait_rise();
        int unsigned tgt;
        tgt = rise_cnt + 1;
        for (int i = 0; i < 3000 && rise_cnt < tgt; i++) @(posedge i_clk);
        checks++;
        if (rise_cnt < tgt) begin
            errors++;
            $display("FAIL wait_rise: no rising edge within budget (rises=%0d want %0d)", rise_cnt, tgt);
        end
    endtask

    task automatic wait_fall();
        int unsigned tgt;
        tgt = fall_cnt + 1;
        for (int i = 0; i < 3000 && fall_cnt < tgt; i++) @(posedge i_clk);
        checks++;
        if (fall_cnt < tgt) begin
            errors++;
            $display("FAIL wait_fall: no falling edge within budget (falls=%0d want %0d)", fall_cnt, tgt);
        end
    endtask

    task automatic check_high(input string name, input int unsigned exp);
        checks++;
        if (high_len !== exp) begin
            errors++;
            $display("FAIL %s: high time %0d clocks, expected %0d", name, high_len, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", o_pwm); end
        checks++;
        if (o_value_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_value_ready); end
        checks++;
        if ({o_frame_start, o_clamped, o_error} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {o_frame_start, o_clamped, o_error});
        end
        i_reset = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        checks++;
        if (o_pwm !== 1'b0) begin errors++; $display("FAIL idle_pwm: got %b want 0", o_pwm); end
    endtask

    task automatic test_basic();
        write_word(16'd30);
        checks++;
        if (o_value_ready !== 1'b0 || o_clamped !== 1'b0 || o_error !== 1'b0) begin
            errors++; $display("FAIL basic_accept: ready/clamp/err %b%b%b want 000", o_value_ready, o_clamped, o_error);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_frame_start !== 1'b1 || o_pwm !== 1'b1 || o_value_ready !== 1'b1) begin
            errors++; $display("FAIL basic_load: fs/pwm/ready %b%b%b want 111", o_frame_start, o_pwm, o_value_ready);
        end
        wait_fall();
        check_high("basic_high", 30 * CPU);
        wait_rise();
        checks++;
        if (low_len !== FRAME_CK - 30 * CPU) begin
            errors++; $display("FAIL basic_low: low time %0d want %0d", low_len, FRAME_CK - 30 * CPU);
        end
        checks++;
        if (period !== FRAME_CK) begin
            errors++; $display("FAIL basic_period: period %0d want %0d", period, FRAME_CK);
        end
        wait_fall();
        check_high("basic_repeat", 30 * CPU);
    endtask

    task automatic test_clamp();
        write_word(16'd10);
        checks++;
        if (o_clamped !== 1'b1) begin errors++; $display("FAIL clamp_low_pulse: got %b want 1", o_clamped); end
        wait_rise();
        wait_fall();
        check_high("clamp_low_high", MINW * CPU);
        write_word(16'd100);
        checks++;
        if (o_clamped !== 1'b1) begin errors++; $display("FAIL clamp_high_pulse: got %b want 1", o_clamped); end
        wait_rise();
        wait_fall();
        check_high("clamp_high_high", MAXW * CPU);
        write_word(16'(MAXW));
        checks++;
        if (o_clamped !== 1'b0) begin errors++; $display("FAIL clamp_edge_pulse: got %b want 0", o_clamped); end
        wait_rise();
        wait_fall();
        check_high("clamp_edge_high", MAXW * CPU);
    endtask

    task automatic test_error();
        write_word(16'd30);
        wait_rise();
        wait_fall();
        check_high("error_pre", 30 * CPU);
        write_word(16'h8000 | 16'd40);
        checks++;
        if (o_error !== 1'b1 || o_value_ready !== 1'b1 || o_clamped !== 1'b0) begin
            errors++; $display("FAIL error_pulse: err/ready/clamp %b%b%b want 110", o_error, o_value_ready, o_clamped);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_error !== 1'b0) begin errors++; $display("FAIL error_one_cycle: got %b want 0", o_error); end
        wait_rise();
        wait_fall();
        check_high("error_keep_width", 30 * CPU);
    endtask

    task automatic test_back_to_back();
        int unsigned rises0;
        logic        r;
        write_word(16'd25);
        wait_rise();
        wait_fall();
        check_high("b2b_pre", 25 * CPU);
        write_word(16'd50);
        rises0 = rise_cnt;
        i_value_valid = 1'b1;
        i_value       = 16'd45;
        for (int i = 0; i < 3000; i++) begin
            r = o_value_ready;
            @(posedge i_clk); #1;
            if (r) break;
        end
        i_value_valid = 1'b0;
        i_value       = 16'd0;
        checks++;
        if (rise_cnt !== rises0 + 1 || o_pwm !== 1'b1 || o_value_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept_after_load: rises %0d want %0d, pwm %b ready %b",
                               rise_cnt, rises0 + 1, o_pwm, o_value_ready);
        end
        wait_fall();
        check_high("b2b_first", 50 * CPU);
        wait_rise();
        wait_fall();
        check_high("b2b_second", 45 * CPU);
    endtask

    task automatic test_load_cycle();
        for (int i = 0; i < 3000 && cyc != rise_cyc + FRAME_CK - 1; i++) begin
            @(posedge i_clk); #1;
        end
        i_value_valid = 1'b1;
        i_value       = 16'd35;
        @(posedge i_clk); #1;
        i_value_valid = 1'b0;
        i_value       = 16'd0;
        checks++;
        if (o_frame_start !== 1'b1 || o_pwm !== 1'b1 || o_value_ready !== 1'b0) begin
            errors++; $display("FAIL load_cycle_accept: fs/pwm/ready %b%b%b want 110", o_frame_start, o_pwm, o_value_ready);
        end
        wait_fall();
        check_high("load_cycle_old", 45 * CPU);
        wait_rise();
        wait_fall();
        check_high("load_cycle_new", 35 * CPU);
    endtask

    task automatic test_reset_mid_high();
        int unsigned highs;
        wait_rise();
        repeat (20) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_pwm !== 1'b0 || o_value_ready !== 1'b1 || o_frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_mid_high: pwm/ready/fs %b%b%b want 010", o_pwm, o_value_ready, o_frame_start);
        end
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge i_clk); #1;
            if (o_pwm !== 1'b0) highs++;
        end
        checks++;
        if (highs !== 0) begin errors++; $display("FAIL reset_stays_idle: %0d high cycles want 0", highs); end
        write_word(16'd40);
        @(posedge i_clk); #1;
        checks++;
        if (o_frame_start !== 1'b1 || o_pwm !== 1'b1) begin
            errors++; $display("FAIL reset_restart: fs/pwm %b%b want 11", o_frame_start, o_pwm);
        end
        wait_fall();
        check_high("reset_restart_high", 40 * CPU);
    endtask

    task automatic test_counts();
        checks++;
        if (fs_cnt !== rise_cnt) begin
            errors++; $display("FAIL frame_start_count: %0d pulses, expected %0d", fs_cnt, rise_cnt);
        end
        checks++;
        if (cl_cnt !== 2) begin errors++; $display("FAIL clamp_count: %0d pulses, expected 2", cl_cnt); end
        checks++;
        if (er_cnt !== 1) begin errors++; $display("FAIL error_count: %0d pulses, expected 1", er_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_error();
        test_back_to_back();
        test_load_cycle();
        test_reset_mid_high();
        test_counts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
